// File: rtl/block_refill_ctrl_pkg.sv
// rtl/block_refill_ctrl_pkg.sv - shared sizes, FSM encoding and memory address composition
package block_refill_ctrl_pkg;

  localparam int TAG_W    = 25;
  localparam int WORDS    = 16;
  localparam int WAYS     = 8;
  localparam int SETS     = 2;
  localparam int OFFSET_W = 6;
  localparam int SET_W    = 1;
  localparam int WIDX_W   = 4;
  localparam int PTR_W    = 3;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = TAG_W + SET_W + OFFSET_W;
  localparam int BLK_W    = WORDS * DATA_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Byte address of one word of the line: {tag, set, word index, 2'b00}
  function automatic logic [ADDR_W-1:0] compose_addr(
    input logic [TAG_W-1:0]  t,
    input logic [SET_W-1:0]  s,
    input logic [WIDX_W-1:0] w
  );
    return {t, s, w, 2'b00};
  endfunction

endpackage

// File: rtl/block_refill_ctrl_victim_select.sv
// rtl/block_refill_ctrl_victim_select.sv - lowest invalid way, else round-robin pointer
module victim_select
  import block_refill_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]  valid_in,
  input  logic [PTR_W-1:0] pointer,
  output logic [WAYS-1:0]  line_select,
  output logic             used_rr
);

  // Priority encode the first free way; fall back to the set's pointer when all are valid
  always_comb begin
    line_select = '0;
    used_rr     = 1'b1;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_in[i]) begin
        line_select    = '0;
        line_select[i] = 1'b1;
        used_rr        = 1'b0;
      end
    end
    if (used_rr) begin
      line_select = WAYS'(1) << pointer;
    end
  end

endmodule

// File: rtl/block_refill_ctrl.sv
// rtl/block_refill_ctrl.sv - cache line refill: fetch 16 words, assemble line, write victim way
module block_refill_ctrl
  import block_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              missReq,
  input  logic [TAG_W-1:0]  cpuTag,
  input  logic              cpuSet,
  input  logic [WAYS-1:0]   validIn,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memRvalid,
  output logic [BLK_W-1:0]  blockData,
  output logic [TAG_W-1:0]  tag,
  output logic              valid,
  output logic              setSelect,
  output logic [WAYS-1:0]   lineSelect,
  output logic              fillWrite,
  output logic              busy
);

  logic [2:0]                  state;
  logic [2:0]                  next_state;
  logic [WIDX_W-1:0]           word_idx;
  logic                        victim_rr;
  logic [SETS-1:0][PTR_W-1:0]  rr_ptr;
  logic [WAYS-1:0]             vs_line;
  logic                        vs_rr;

  victim_select u_victim_select (
    .valid_in    (validIn),
    .pointer     (rr_ptr[cpuSet]),
    .line_select (vs_line),
    .used_rr     (vs_rr)
  );

  assign memAddr = compose_addr(tag, setSelect, word_idx);

  // State register; reset abandons any fill in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: one read outstanding at a time, DONE waits for the miss to clear
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (missReq) next_state = ST_REQ;
      ST_REQ:   next_state = ST_WAIT;
      ST_WAIT: begin
        if (memRvalid) begin
          next_state = (word_idx == WIDX_W'(WORDS - 1)) ? ST_WRITE : ST_REQ;
        end
      end
      ST_WRITE: next_state = ST_DONE;
      ST_DONE:  if (!missReq) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Strobes and status decoded from the current state
  always_comb begin
    memRead   = (state == ST_REQ);
    fillWrite = (state == ST_WRITE);
    valid     = (state == ST_WRITE);
    busy      = (state != ST_IDLE);
  end

  // Request latch at acceptance, word assembly, and round-robin advance on the line write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag        <= '0;
      setSelect  <= 1'b0;
      lineSelect <= '0;
      victim_rr  <= 1'b0;
      word_idx   <= '0;
      blockData  <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (missReq) begin
            tag        <= cpuTag;
            setSelect  <= cpuSet;
            lineSelect <= vs_line;
            victim_rr  <= vs_rr;
            word_idx   <= '0;
          end
        end
        ST_WAIT: begin
          if (memRvalid) begin
            blockData[{word_idx, 5'd0} +: DATA_W] <= memRdata;
            if (word_idx != WIDX_W'(WORDS - 1)) begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (victim_rr) begin
            rr_ptr[setSelect] <= rr_ptr[setSelect] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_refill_ctrl.sv
// tb/tb_block_refill_ctrl.sv - self-checking bench for block_refill_ctrl
module tb_block_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         missReq;
  logic [24:0]  cpuTag;
  logic         cpuSet;
  logic [7:0]   validIn;
  logic         memRead;
  logic [31:0]  memAddr;
  logic [31:0]  memRdata;
  logic         memRvalid;
  logic [511:0] blockData;
  logic [24:0]  tag;
  logic         valid;
  logic         setSelect;
  logic [7:0]   lineSelect;
  logic         fillWrite;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int rr[2];

  typedef struct {
    logic [24:0] t;
    logic        s;
    logic [7:0]  vin;
    logic [7:0]  exp_line;
    int          maxd;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  block_refill_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .missReq    (missReq),
    .cpuTag     (cpuTag),
    .cpuSet     (cpuSet),
    .validIn    (validIn),
    .memRead    (memRead),
    .memAddr    (memAddr),
    .memRdata   (memRdata),
    .memRvalid  (memRvalid),
    .blockData  (blockData),
    .tag        (tag),
    .valid      (valid),
    .setSelect  (setSelect),
    .lineSelect (lineSelect),
    .fillWrite  (fillWrite),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Victim rule: lowest invalid way; when all valid, the set's pointer, which then advances mod 8
  function automatic logic [7:0] model_victim(input logic [7:0] vin, input logic s);
    int p;
    for (int i = 0; i < 8; i++) begin
      if (!vin[i]) return 8'(1 << i);
    end
    p = rr[s];
    rr[s] = (p + 1) % 8;
    return 8'(1 << p);
  endfunction

  // One complete miss: memory model, address/ordering checks, line write checks, DONE handshake
  task automatic fill(input logic [24:0] t, input logic s, input logic [7:0] vin,
                      input logic [7:0] exp_line, input int maxd, input int hold,
                      input bit drop_early, input bit rnd_data, input int abort_beats);
    logic [31:0]  data [16];
    logic [511:0] exp_blk;
    logic [511:0] cap_blk;
    logic [7:0]   cap_line;
    logic [24:0]  cap_tag;
    logic         cap_set;
    logic         cap_valid;
    logic [31:0]  exp_addr;
    int n, reads, writes, cd;
    bit outstanding, addr_ok, done_seen, hold_ok;
    n = 0; reads = 0; writes = 0; cd = 0;
    outstanding = 0; addr_ok = 1; done_seen = 0; hold_ok = 1;
    cap_blk = '0; cap_line = '0; cap_tag = '0; cap_set = 0; cap_valid = 0;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      data[i] = rnd_data ? $urandom : 32'hA000_0000 + 32'(i);
      exp_blk[32*i +: 32] = data[i];
    end
    @(negedge clk);
    missReq = 1'b1; cpuTag = t; cpuSet = s; validIn = vin;
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 0) chk("busy_after_accept", 512'(busy), 512'(1));
      memRvalid = 1'b0;
      validIn = 8'($urandom);
      if (drop_early && reads >= 1) missReq = 1'b0;
      if (fillWrite) begin
        writes++;
        done_seen = 1;
        cap_blk = blockData; cap_line = lineSelect; cap_tag = tag;
        cap_set = setSelect; cap_valid = valid;
      end
      if (memRead) begin
        exp_addr = 32'(t) * 128 + 32'(s) * 64 + 32'(reads) * 4;
        if (outstanding || memAddr !== exp_addr) addr_ok = 0;
        reads++;
        outstanding = 1;
        cd = $urandom_range(0, maxd);
      end else if (outstanding) begin
        if (cd == 0) begin
          memRvalid = 1'b1;
          memRdata = data[n % 16];
          n++;
          outstanding = 0;
        end else begin
          cd--;
        end
      end
      if (abort_beats >= 0 && n == abort_beats && !memRvalid) begin
        chk("no_write_before_abort", 512'(writes), 512'(0));
        return;
      end
    end
    memRvalid = 1'b0;
    chk("fill_write_seen", 512'(done_seen), 512'(1));
    chk("read_count", 512'(reads), 512'(16));
    chk("addr_seq_single_outstanding", 512'(addr_ok), 512'(1));
    chk("line_select", 512'(cap_line), 512'(exp_line));
    chk("set_select", 512'(cap_set), 512'(s));
    chk("tag", 512'(cap_tag), 512'(t));
    chk("valid", 512'(cap_valid), 512'(1));
    chk("block_data", cap_blk, exp_blk);
    if (hold > 0 && !drop_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (memRead || fillWrite || !busy) hold_ok = 0;
        memRvalid = 1'($urandom);
        memRdata = $urandom;
      end
      memRvalid = 1'b0;
      chk("done_hold_quiet", 512'(hold_ok), 512'(1));
      chk("busy_before_release", 512'(busy), 512'(1));
      missReq = 1'b0;
      @(negedge clk);
      chk("busy_drop_one_cycle", 512'(busy), 512'(0));
    end else begin
      missReq = 1'b0;
      for (int k = 0; k < 5 && busy; k++) @(negedge clk);
      chk("busy_cleared", 512'(busy), 512'(0));
    end
    chk("block_hold_idle", blockData, exp_blk);
    chk("line_hold_idle", 512'(lineSelect), 512'(exp_line));
  endtask

  initial begin
    reset = 1'b1; missReq = 1'b0; cpuTag = '0; cpuSet = 1'b0;
    validIn = '0; memRdata = '0; memRvalid = 1'b0;
    rr[0] = 0; rr[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {memRead, memAddr, fillWrite, busy, tag, valid, setSelect, lineSelect},
        512'(0));
    chk("reset_block", blockData, 512'(0));
    reset = 1'b0;

    tbl.push_back('{25'h0ABCDE,  1'b1, 8'h00,       8'h01, 0, 0});
    tbl.push_back('{25'h1234567, 1'b0, 8'b11101111, 8'h10, 2, 0});
    for (int k = 0; k < 9; k++) begin
      tbl.push_back('{25'(32'h100 + k), 1'b0, 8'hFF, 8'(1 << (k % 8)), 1, (k == 0) ? 10 : 0});
    end
    tbl.push_back('{25'h1FFFFFF, 1'b1, 8'hFF, 8'h01, 0, 0});

    foreach (tbl[i]) begin
      fill(tbl[i].t, tbl[i].s, tbl[i].vin, tbl[i].exp_line, tbl[i].maxd, tbl[i].hold,
           1'b0, (i != 0), -1);
    end

    fill(25'h0F0F0F0, 1'b1, 8'h00, 8'h01, 1, 0, 1'b0, 1'b1, 7);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {memRead, memAddr, fillWrite, busy, tag, valid, setSelect, lineSelect},
        512'(0));
    chk("async_reset_block", blockData, 512'(0));
    missReq = 1'b0;
    memRvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rr[0] = 0; rr[1] = 0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (fillWrite || busy) stray++;
      end
      chk("no_write_after_abort", 512'(stray), 512'(0));
    end
    fill(25'h0F0F0F0, 1'b1, 8'h00, 8'h01, 0, 0, 1'b0, 1'b1, -1);

    for (int r = 0; r < 20; r++) begin
      logic [24:0] t;
      logic        s;
      logic [7:0]  vin;
      logic [7:0]  exp_line;
      t = 25'($urandom);
      s = 1'($urandom);
      vin = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      exp_line = model_victim(vin, s);
      fill(t, s, vin, exp_line, 5, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
           1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
